// File: rtl/mux_scan_sel.sv
// Two-stage pipelined CH:1 channel selector with valid/ready handshake.
// Optional auto-scan channel sequencing is compiled in when MUX_SCAN_EN is defined.
module mux_scan_sel #(
  parameter int WIDTH = 8,
  parameter int CH = 8,
  localparam int SELW = $clog2(CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH*WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]       sel,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int GRP = CH / 4;
  localparam int HIW = (SELW > 2) ? SELW - 2 : 1;

  logic                  stall_s;
  logic                  accept_s;
  logic [SELW-1:0]       idx_s;
  logic [WIDTH-1:0]      part_s [GRP];
  logic [HIW-1:0]        hi_s;

  logic                  s1_valid_r;
  logic [WIDTH-1:0]      s1_part_r [GRP];
  logic [SELW-1:0]       s1_idx_r;
  logic                  out_valid_r;
  logic [WIDTH-1:0]      out_data_r;
  logic [SELW-1:0]       out_ch_r;

  assign stall_s  = out_valid_r & ~out_ready;
  assign accept_s = in_valid & ~stall_s;
  assign in_ready = ~stall_s;

`ifdef MUX_SCAN_EN
  logic            mode_r;
  logic [SELW-1:0] scan_ptr_r;
  logic [SELW-1:0] scan_cur_s;
  logic [SELW-1:0] scan_nxt_s;

  // Scan index selection; a rising mode edge restarts the scan at channel 0 in the same cycle
  always_comb begin
    scan_cur_s = scan_ptr_r;
    scan_nxt_s = scan_ptr_r;
    idx_s      = sel;
    if (mode) begin
      if (!mode_r) begin
        scan_cur_s = {SELW{1'b0}};
      end else begin
        scan_cur_s = scan_ptr_r;
      end
      idx_s = scan_cur_s;
      if (accept_s) begin
        scan_nxt_s = scan_cur_s + {{(SELW-1){1'b0}}, 1'b1};
      end else begin
        scan_nxt_s = scan_cur_s;
      end
    end else begin
      scan_nxt_s = scan_ptr_r;
    end
  end

  // Scan pointer and registered mode for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r     <= 1'b0;
      scan_ptr_r <= {SELW{1'b0}};
    end else begin
      mode_r     <= mode;
      scan_ptr_r <= scan_nxt_s;
    end
  end
`else
  logic unused_mode_s;
  assign unused_mode_s = mode;
  assign idx_s         = sel;
`endif

  // First-level 4:1 selection inside each group of four channels
  always_comb begin
    for (int g = 0; g < GRP; g++) begin
      part_s[g] = in_data[(4*g + int'(idx_s[1:0]))*WIDTH +: WIDTH];
    end
  end

  assign hi_s = HIW'(s1_idx_r >> 2);

  // Stage 1: partial results and index, frozen while the output is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_idx_r   <= {SELW{1'b0}};
      for (int g = 0; g < GRP; g++) begin
        s1_part_r[g] <= {WIDTH{1'b0}};
      end
    end else if (!stall_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_idx_r <= idx_s;
        for (int g = 0; g < GRP; g++) begin
          s1_part_r[g] <= part_s[g];
        end
      end
    end
  end

  // Stage 2: final group selection; data holds its last value when not valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_ch_r    <= {SELW{1'b0}};
    end else if (!stall_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_data_r <= s1_part_r[hi_s];
        out_ch_r   <= s1_idx_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Scoreboard bench for mux_scan_sel (CH=8/WIDTH=8 plus a CH=16/WIDTH=4 instance).
// Scan-mode steps are included when MUX_SCAN_EN is defined.
module tb_mux_scan_sel;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_data = 64'h0;
  logic [2:0]  sel = 3'd0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_valid;
  logic        out_ready = 1'b1;

  logic [63:0] in16 = 64'h0;
  logic [3:0]  sel16 = 4'd0;
  logic        mode16 = 1'b0;
  logic        v16 = 1'b0;
  logic        rdy16;
  logic [3:0]  od16;
  logic [3:0]  och16;
  logic        ov16;
  logic        ordy16 = 1'b1;

  int total = 0;
  int bad = 0;
  bit fixed_pat = 1'b0;
  logic [10:0] sb_q [$];
  logic [2:0]  m_ptr = 3'd0;
  logic        m_mode_prev = 1'b0;

  always #5 clk = ~clk;

  mux_scan_sel #(.WIDTH(8), .CH(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_scan_sel #(.WIDTH(4), .CH(16)) dut16 (
    .clk(clk), .rst(rst), .in_data(in16), .sel(sel16), .mode(mode16),
    .in_valid(v16), .in_ready(rdy16), .out_data(od16),
    .out_ch(och16), .out_valid(ov16), .out_ready(ordy16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, then pop/compare outputs and push accepted requests
  task automatic tick(input logic v, input logic [2:0] s, input logic m, input logic rdy);
    logic [2:0]  idx;
    logic [2:0]  cur;
    logic        acc;
    logic [10:0] e;
    @(negedge clk);
    in_valid  = v;
    sel       = s;
    mode      = m;
    out_ready = rdy;
    if (fixed_pat) in_data = 64'hA7A6A5A4A3A2A1A0;
    else           in_data = {$urandom(), $urandom()};
    #1;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("out_ch", 64'(out_ch), 64'(e[10:8]));
        chk("out_data", 64'(out_data), 64'(e[7:0]));
      end
    end
    acc = in_valid && in_ready;
    idx = s;
    cur = m_ptr;
`ifdef MUX_SCAN_EN
    if (m) begin
      cur = m_mode_prev ? m_ptr : 3'd0;
      idx = cur;
      m_ptr = acc ? cur + 3'd1 : cur;
    end
    m_mode_prev = m;
`endif
    if (acc) sb_q.push_back({idx, in_data[idx*8 +: 8]});
  endtask

  initial begin
    logic [7:0] held;
    logic [3:0] exp16;

    // reset state
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ch", 64'(out_ch), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // REQ-034 latency and value
    fixed_pat = 1'b1;
    tick(1'b1, 3'd5, 1'b0, 1'b1);
    tick(1'b0, 3'd0, 1'b0, 1'b1);
    chk("lat_t1_valid", 64'(out_valid), 64'd0);
    tick(1'b0, 3'd0, 1'b0, 1'b1);
    chk("lat_t2_valid", 64'(out_valid), 64'd1);
    chk("lat_t2_data", 64'(out_data), 64'hA5);
    chk("lat_t2_ch", 64'(out_ch), 64'd5);
    tick(1'b0, 3'd0, 1'b0, 1'b1);
    chk("hold_data_after_valid", 64'(out_data), 64'hA5);
    fixed_pat = 1'b0;

    // back-to-back manual selects with random data
    for (int i = 0; i < 8; i++) tick(1'b1, 3'(7 - i), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 3'd0, 1'b0, 1'b1);
    chk("drain_manual", 64'(sb_q.size()), 64'd0);

    // stall: out_ready low for 4 cycles with in_valid high
    tick(1'b1, 3'd1, 1'b0, 1'b1);
    tick(1'b1, 3'd2, 1'b0, 1'b1);
    tick(1'b1, 3'd3, 1'b0, 1'b0);
    held = out_data;
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_ready0", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 3'd3, 1'b0, 1'b0);
      chk("stall_ready", 64'(in_ready), 64'd0);
      chk("stall_data_const", 64'(out_data), 64'(held));
    end
    tick(1'b1, 3'd4, 1'b0, 1'b1);
    chk("release_accept", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) tick(1'b0, 3'd0, 1'b0, 1'b1);
    chk("drain_stall", 64'(sb_q.size()), 64'd0);

`ifdef MUX_SCAN_EN
    // scan: 10 accepts wrap 0..7,0,1
    for (int i = 0; i < 10; i++) tick(1'b1, 3'd6, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 3'd6, 1'b1, 1'b1);
    chk("drain_scan", 64'(sb_q.size()), 64'd0);
    // scan at ptr=3 then mode 1->0->1 restarts at channel 0
    tick(1'b0, 3'd6, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 3'd6, 1'b1, 1'b1);
    tick(1'b0, 3'd6, 1'b0, 1'b1);
    tick(1'b1, 3'd6, 1'b1, 1'b1);
    tick(1'b0, 3'd6, 1'b1, 1'b1);
    tick(1'b0, 3'd6, 1'b1, 1'b1);
    chk("restart_ch0", 64'(out_ch), 64'd0);
    tick(1'b0, 3'd6, 1'b0, 1'b1);
    chk("drain_restart", 64'(sb_q.size()), 64'd0);
`else
    // mode input ignored: sel still chooses the channel
    tick(1'b1, 3'd3, 1'b1, 1'b1);
    tick(1'b0, 3'd0, 1'b1, 1'b1);
    tick(1'b0, 3'd0, 1'b1, 1'b1);
    chk("mode_ignored_ch", 64'(out_ch), 64'd3);
    tick(1'b0, 3'd0, 1'b0, 1'b1);
`endif

    // reset with two samples in flight
    tick(1'b1, 3'd6, mode, 1'b1);
    tick(1'b1, 3'd7, mode, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_out_ch", 64'(out_ch), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    sb_q.delete();
    m_ptr = 3'd0;
    m_mode_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 3'd0, 1'b0, 1'b1);
      chk("post_rst_no_valid", 64'(out_valid), 64'd0);
    end
`ifdef MUX_SCAN_EN
    tick(1'b1, 3'd5, 1'b1, 1'b1);
    tick(1'b0, 3'd5, 1'b1, 1'b1);
    tick(1'b0, 3'd5, 1'b1, 1'b1);
    chk("post_rst_scan_ch0", 64'(out_ch), 64'd0);
`endif
    tick(1'b0, 3'd0, 1'b0, 1'b1);
    chk("drain_final", 64'(sb_q.size()), 64'd0);

    // CH=16, WIDTH=4, sel=15, later in_data change must not leak through
    @(negedge clk);
    v16 = 1'b1;
    sel16 = 4'd15;
    in16 = {$urandom(), $urandom()};
    exp16 = in16[63:60];
    #1;
    chk("c16_ready", 64'(rdy16), 64'd1);
    @(negedge clk);
    v16 = 1'b0;
    in16 = ~in16;
    sel16 = 4'd2;
    #1;
    chk("c16_t1_valid", 64'(ov16), 64'd0);
    @(negedge clk);
    #1;
    chk("c16_t2_valid", 64'(ov16), 64'd1);
    chk("c16_t2_data", 64'(od16), 64'(exp16));
    chk("c16_t2_ch", 64'(och16), 64'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
